hazard_ctrl_unit: RTL

- Parametrised successor of the five-stage CPU's data-conflict and syscall-halt logic.
- Centralises every pipeline enable, bubble and flush for IF/ID/EX/MEM/WB.
- Adds selectable forwarding, load-use stall, a multi-cycle MUL/DIV busy tracker and a halt/resume FSM driven by GO.
- Instantiated once in the CPU top; all inputs come from ID-stage decode and the stage signal registers.

---
 rtl/hazard_ctrl_unit.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline hazard controller for the five-stage CPU.
// Resolves register and HI/LO data conflicts (forwarding or stall-only),
// tracks multi-cycle MUL/DIV occupancy, drives all stage enables, bubbles
// and flushes, and runs the syscall halt / GO resume state machine.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined;
// otherwise cyc_cnt, stall_cnt and flush_cnt are tied to zero.
module hazard_ctrl_unit #(
   parameter int RNUM_W     = 5,
   parameter int FORWARD    = 1,
   parameter int MULDIV_LAT = 4,
   parameter int CNT_W      = 32
) (
   input  logic              clk,
   input  logic              CLR,
   input  logic              GO,
   input  logic              id_r1_used,
   input  logic              id_r2_used,
   input  logic              id_hi_used,
   input  logic              id_lo_used,
   input  logic [RNUM_W-1:0] id_r1_num,
   input  logic [RNUM_W-1:0] id_r2_num,
   input  logic              id_muldiv,
   input  logic              ex_reg_write,
   input  logic              ex_load,
   input  logic              ex_hilo_write,
   input  logic [RNUM_W-1:0] ex_wb_num,
   input  logic              mem_reg_write,
   input  logic              mem_hilo_write,
   input  logic [RNUM_W-1:0] mem_wb_num,
   input  logic              wb_reg_write,
   input  logic [RNUM_W-1:0] wb_wb_num,
   input  logic              ex_branch_taken,
   input  logic              wb_syscall_halt,
   output logic              pc_en,
   output logic              if_id_en,
   output logic              id_ex_en,
   output logic              ex_mem_en,
   output logic              mem_wb_en,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              stall_data,
   output logic              muldiv_busy,
   output logic              halted,
   output logic [CNT_W-1:0]  cyc_cnt,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HALT   = 2'd1,
      ST_RESUME = 2'd2
   } state_t;

   localparam logic [3:0] MD_LAT = 4'(MULDIV_LAT);

   state_t     state_reg, state_next;
   logic       go_reg;
   logic [3:0] md_cnt_reg, md_cnt_next;
   logic       go_rise, halt_now, md_issue;
   logic       ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
   logic       reg_hazard, hilo_hazard, md_hazard;

   // A source matches a destination only when both sides are live and the
   // destination is not r0 (r0 is hard-wired to zero and never written).
   function automatic logic reg_match(input logic used, input logic wr,
                                      input logic [RNUM_W-1:0] src,
                                      input logic [RNUM_W-1:0] dst);
      return used & wr & (src == dst) & (dst != '0);
   endfunction

   assign ex_a  = reg_match(id_r1_used, ex_reg_write,  id_r1_num, ex_wb_num);
   assign ex_b  = reg_match(id_r2_used, ex_reg_write,  id_r2_num, ex_wb_num);
   assign mem_a = reg_match(id_r1_used, mem_reg_write, id_r1_num, mem_wb_num);
   assign mem_b = reg_match(id_r2_used, mem_reg_write, id_r2_num, mem_wb_num);
   assign wb_a  = reg_match(id_r1_used, wb_reg_write,  id_r1_num, wb_wb_num);
   assign wb_b  = reg_match(id_r2_used, wb_reg_write,  id_r2_num, wb_wb_num);

   assign muldiv_busy = (md_cnt_reg != 4'd0);
   assign hilo_hazard = (id_hi_used | id_lo_used) &
                        (ex_hilo_write | mem_hilo_write | muldiv_busy);
   assign md_hazard   = id_muldiv & muldiv_busy;
   assign stall_data  = reg_hazard | hilo_hazard | md_hazard;
   assign go_rise     = GO & ~go_reg;
   assign halted      = (state_reg == ST_HALT);

   // Register-operand resolution: forwarding mux select or stall-only.
   always_comb begin
      reg_hazard = 1'b0;
      fwd_a      = 2'd0;
      fwd_b      = 2'd0;
      if (FORWARD == 0) begin
         reg_hazard = ex_a | ex_b | mem_a | mem_b;
      end else begin
         // Only a load in EX has no result yet; everything else forwards.
         reg_hazard = ex_load & (ex_a | ex_b);
         fwd_a = ex_a ? 2'd1 : mem_a ? 2'd2 : wb_a ? 2'd3 : 2'd0;
         fwd_b = ex_b ? 2'd1 : mem_b ? 2'd2 : wb_b ? 2'd3 : 2'd0;
      end
   end

   // Halt FSM next state plus the prioritised enable/flush outputs.
   always_comb begin
      state_next  = state_reg;
      halt_now    = 1'b0;
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      case (state_reg)
         ST_RUN: begin
            if (wb_syscall_halt) begin
               state_next = ST_HALT;
               halt_now   = 1'b1;
            end
         end
         ST_HALT: begin
            halt_now = 1'b1;
            if (go_rise) state_next = ST_RESUME;
         end
         // The syscall still sits in WB here; ignoring it lets it retire.
         ST_RESUME: state_next = ST_RUN;
         default:   state_next = ST_RUN;
      endcase
      if (halt_now) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
         mem_wb_en = 1'b0;
      end else if (ex_branch_taken) begin
         // The stalled ID instruction is wrong-path, so the branch wins.
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (stall_data) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   // MUL/DIV occupancy: reload on a real issue into EX, else count down.
   assign md_issue = id_muldiv & ~halt_now & ~ex_branch_taken & ~stall_data;

   always_comb begin
      md_cnt_next = md_cnt_reg;
      if (state_reg != ST_HALT) begin
         if (md_issue)
            md_cnt_next = MD_LAT;
         else if (md_cnt_reg != 4'd0)
            md_cnt_next = md_cnt_reg - 4'd1;
      end
   end

   // State, GO history and MUL/DIV counter registers.
   always_ff @(posedge clk or negedge CLR) begin
      if (!CLR) begin
         state_reg  <= ST_RUN;
         go_reg     <= 1'b0;
         md_cnt_reg <= 4'd0;
      end else begin
         state_reg  <= state_next;
         go_reg     <= GO;
         md_cnt_reg <= md_cnt_next;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cyc_reg, stall_reg, flush_reg;

   // Saturating performance counters.
   always_ff @(posedge clk or negedge CLR) begin
      if (!CLR) begin
         cyc_reg   <= '0;
         stall_reg <= '0;
         flush_reg <= '0;
      end else begin
         if (state_reg != ST_HALT && cyc_reg != '1)
            cyc_reg <= cyc_reg + CNT_ONE;
         if (stall_data && !ex_branch_taken && stall_reg != '1)
            stall_reg <= stall_reg + CNT_ONE;
         if (ex_branch_taken && flush_reg != '1)
            flush_reg <= flush_reg + CNT_ONE;
      end
   end

   assign cyc_cnt   = cyc_reg;
   assign stall_cnt = stall_reg;
   assign flush_cnt = flush_reg;
`else
   assign cyc_cnt   = '0;
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
